disp_scan: RTL and testbench
============================

# disp_scan

Time-multiplexed display scanner sitting directly upstream of the seven-segment decoder `disp_deco`. Latches a multi-digit hex value on a load strobe, then cycles through the digits. For each digit it presents the 4-bit nibble to the decoder and drives the matching common-anode enable. Includes a dead cycle between digits to suppress ghosting.

## Interface
- `N_DIGITS`, 4: number of multiplexed digits; must be ≥ 1.
- `REFRESH_DIV`, 50000: clock cycles per digit slot, including the dead cycle; must be ≥ 2.

- `clk`  in  1: single system clock; all logic is on its rising edge.
- `rst`  in  1: reset. Synchronous and active-high.
- `load`  in  1: capture `value` on this edge.
- `value`  in  4*N_DIGITS: hex digits; digit i is `value[4i+3:4i]`, and digit 0 is rightmost.
- `nibble`  out  4: goes to the decoder; `nibble[3]`→x, `[2]`→y, `[1]`→z, `[0]`→w.
- `anode`  out  N_DIGITS: digit enables, active-low, one-hot-low or all-ones.
- `slot_tick`  out  1: one-cycle pulse on the first cycle of each digit slot.

## Operation
- Registers:
  - `val_q` is 4*N_DIGITS wide.
  - `idx` counts 0..N_DIGITS-1.
  - `cnt` counts 0..REFRESH_DIV-1.
  - A 2-state FSM holds the slot phase.
- FSM states:
  - BLANK: the first cycle of a slot. `anode` is all-ones, `nibble` = `val_q` digit `idx`, `slot_tick`=1. Always → DRIVE on the next cycle.
  - DRIVE: `anode[idx]`=0, all other anode bits are 1, `nibble` = digit `idx` of `val_q`.
  - DRIVE → BLANK when `cnt`==REFRESH_DIV-1. In that transition `idx` increments and `cnt` returns to 0.
- Counters:
  - `cnt` increments every cycle and resets to 0 on entry to BLANK.
  - `idx` wraps from N_DIGITS-1 to 0.
- Load:
  - `val_q` ← `value` when `load`=1; loads are accepted in any state.
  - A load does not disturb the FSM, `cnt`, or `idx`.
  - When a load coincides with a slot boundary, both actions take effect on the same edge.
- Outputs are registered. No combinational path exists from `load`/`value` to any output.
- Width rule: `idx` is $clog2(N_DIGITS) bits, minimum 1.

## Timing
- Reset values, held while `rst`=1:
  - `val_q`=0, `idx`=0, `cnt`=0, state=BLANK.
  - `anode`=all-ones, `nibble`=0, `slot_tick`=0.
- First active cycle after `rst` falls: BLANK for digit 0, with `slot_tick`=1.
- Each slot lasts exactly REFRESH_DIV cycles: 1 BLANK cycle plus REFRESH_DIV-1 DRIVE cycles. A full frame is N_DIGITS*REFRESH_DIV cycles.
- Load latency: `load` sampled at edge k → `val_q` updated at edge k → `nibble` reflects it after edge k+1.
- Mid-operation reset: at the next edge, all state returns to reset values regardless of FSM phase. A `load` asserted together with `rst` is discarded.
- At N_DIGITS=1, `idx` stays 0 and the slot sequence still runs.

## Configuration
- `DISP_SCAN_LZ_BLANK_EN` defined: leading-zero blanking.
  - Any digit i>0 whose value, and the value of every digit above it, is 0 keeps its anode at 1 during DRIVE.
  - Digit 0 is never blanked, so `val_q`=0 shows a single "0".
  - The blank mask is registered from `val_q`, giving 1 extra cycle of latency for blanking only.
- Not defined: every digit is driven in DRIVE, and leading zeros are shown.

## Structure
- Package `disp_pkg` holds:
  - the `nibble_t` typedef (logic [3:0]);
  - the `scan_state_t` enum {BLANK, DRIVE};
  - the default constants `DISP_N_DIGITS`=4 and `DISP_REFRESH_DIV`=50000.
- Sub-module `disp_refresh_tick` contains the `cnt` prescaler. It emits an end-of-slot strobe when `cnt`==REFRESH_DIV-1 and takes a synchronous clear. The FSM, `idx`, `val_q` and the output registers stay in `disp_scan`.

## Test plan
Bench configuration: N_DIGITS=4, REFRESH_DIV=4.

1. Reset release:
   - Stimulus: hold `rst` for 3 cycles, then deassert.
   - Required: during reset, `anode`=4'b1111, `nibble`=0, `slot_tick`=0. First cycle after release: BLANK with `slot_tick`=1. Next cycle: `anode`=4'b1110.
2. Scan order:
   - Stimulus: load 16'h1234 and run 2 frames.
   - Required: DRIVE nibbles are 4,3,2,1 with anodes 1110, 1101, 1011, 0111. Every slot is 4 cycles long and begins with 1 all-ones cycle.
3. Load mid-slot:
   - Stimulus: during digit 2 DRIVE, load 16'hABCD.
   - Required: `nibble` changes from 2 to B exactly 1 cycle later. `idx` and `cnt` are unaffected.
4. Load at a slot boundary:
   - Stimulus: assert `load` on the edge with `cnt`==3.
   - Required: the new `idx` and the new value both apply. The next BLANK shows the new digit.
5. Reset mid-DRIVE:
   - Stimulus: assert `rst` on the 2nd DRIVE cycle of digit 3, together with `load`.
   - Required: all reset values appear at the next edge, and `val_q`=0.
6. With `DISP_SCAN_LZ_BLANK_EN`:
   - Stimulus: load 16'h0050, then load 16'h0000.
   - Required for 16'h0050: digits 3 and 2 stay at anode 1 through DRIVE, and digits 1 and 0 are driven. Required for 16'h0000: only digit 0 is driven, with `nibble`=0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and default sizing for the multiplexed seven-segment scanner.
// Leading-zero blanking in disp_scan is enabled by defining DISP_SCAN_LZ_BLANK_EN.
package disp_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam int DISP_N_DIGITS    = 4;
  localparam int DISP_REFRESH_DIV = 50000;

endpackage

// File: rtl/disp_refresh_tick.sv
// Slot prescaler for disp_scan: counts 0..REFRESH_DIV-1 and flags the last
// cycle of a slot. The strobe is registered and always equals (cnt == last).
module disp_refresh_tick
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = DISP_REFRESH_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic slot_end
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             slot_end_r;

  // Next count: wrap at the last cycle of a slot or on an explicit clear.
  always_comb begin
    cnt_next_s = cnt_r;
    if (clr || (cnt_r == CNT_LAST)) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
  end

  // Counter and look-ahead end-of-slot strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      slot_end_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_next_s;
      slot_end_r <= (cnt_next_s == CNT_LAST);
    end
  end

  assign slot_end = slot_end_r;

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed hex display scanner feeding disp_deco: one blank cycle plus
// REFRESH_DIV-1 drive cycles per digit. Define DISP_SCAN_LZ_BLANK_EN for leading-zero blanking.
module disp_scan
  import disp_pkg::*;
#(
  parameter int N_DIGITS    = DISP_N_DIGITS,
  parameter int REFRESH_DIV = DISP_REFRESH_DIV
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  output logic [3:0]            nibble,
  output logic [N_DIGITS-1:0]   anode,
  output logic                  slot_tick
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [0:0] ST_BLANK = BLANK;
  localparam logic [0:0] ST_DRIVE = DRIVE;

  logic [0:0]            state_r;
  logic [0:0]            state_next_s;
  logic [IDX_W-1:0]      idx_r;
  logic [4*N_DIGITS-1:0] val_r;
  logic                  slot_end_s;
  logic                  clr_s;
  nibble_t               cur_nib_s;
  logic [N_DIGITS-1:0]   sel_anode_s;
  logic [N_DIGITS-1:0]   lz_mask_s;
  logic [N_DIGITS-1:0]   anode_r;
  nibble_t               nibble_r;
  logic                  slot_tick_r;

  disp_refresh_tick #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_s),
    .slot_end (slot_end_s)
  );

  // Slot phase: a single blank cycle, then drive until the prescaler wraps.
  always_comb begin
    state_next_s = state_r;
    clr_s        = 1'b0;
    case (state_r)
      ST_BLANK: begin
        state_next_s = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (slot_end_s) begin
          state_next_s = ST_BLANK;
          clr_s        = 1'b1;
        end else begin
          state_next_s = ST_DRIVE;
        end
      end
      default: begin
        state_next_s = ST_BLANK;
      end
    endcase
  end

  // Phase register and digit index; the index advances on the drive-to-blank edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_BLANK;
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (clr_s) begin
        idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : (idx_r + IDX_W'(1));
      end
    end
  end

  // Display value latch; independent of the scan so a load never shifts timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_r <= {(4*N_DIGITS){1'b0}};
    end else if (load) begin
      val_r <= value;
    end
  end

`ifdef DISP_SCAN_LZ_BLANK_EN
  logic [N_DIGITS-1:0] lz_mask_d_s;
  logic [N_DIGITS-1:0] lz_mask_r;
  logic                lz_zero_s;

  // A digit above 0 is blanked when it and every higher digit are zero.
  always_comb begin
    lz_zero_s   = 1'b1;
    lz_mask_d_s = {N_DIGITS{1'b0}};
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      lz_zero_s      = lz_zero_s & (val_r[4*i +: 4] == 4'h0);
      lz_mask_d_s[i] = lz_zero_s;
    end
  end

  // Mask is registered so the blanking decode stays off the nibble path.
  always_ff @(posedge clk) begin
    if (rst) begin
      lz_mask_r <= {N_DIGITS{1'b0}};
    end else begin
      lz_mask_r <= lz_mask_d_s;
    end
  end

  assign lz_mask_s = lz_mask_r;
`else
  assign lz_mask_s = {N_DIGITS{1'b0}};
`endif

  // Select the current digit's nibble and its active-low enable.
  always_comb begin
    cur_nib_s   = 4'h0;
    sel_anode_s = {N_DIGITS{1'b1}};
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_r == IDX_W'(i)) begin
        cur_nib_s      = val_r[4*i +: 4];
        sel_anode_s[i] = lz_mask_s[i];
      end else begin
        sel_anode_s[i] = 1'b1;
      end
    end
  end

  // Output registers: all enables high in the blank cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      anode_r     <= {N_DIGITS{1'b1}};
      nibble_r    <= 4'h0;
      slot_tick_r <= 1'b0;
    end else begin
      slot_tick_r <= (state_r == ST_BLANK);
      nibble_r    <= cur_nib_s;
      anode_r     <= (state_r == ST_DRIVE) ? sel_anode_s : {N_DIGITS{1'b1}};
    end
  end

  assign anode     = anode_r;
  assign nibble    = nibble_r;
  assign slot_tick = slot_tick_r;

endmodule

// File: tb/tb_disp_scan.sv
// Self-checking bench for disp_scan (N_DIGITS=4, REFRESH_DIV=4) against a
// cycle-count model of the scan sequence; covers DISP_SCAN_LZ_BLANK_EN when defined.
module tb_disp_scan;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  nibble;
  logic [3:0]  anode;
  logic        slot_tick;

  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model: active edges since reset, displayed value, blanking mask.
  int          t     = 0;
  logic [15:0] mval  = 16'h0;
  logic [3:0]  mmask = 4'h0;

  disp_scan #(
    .N_DIGITS    (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value     (value),
    .nibble    (nibble),
    .anode     (anode),
    .slot_tick (slot_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  // Digits above 0 that are zero together with every higher digit.
  function automatic logic [3:0] lz_of(input logic [15:0] v);
    lz_of = 4'b0000;
`ifdef DISP_SCAN_LZ_BLANK_EN
    for (int d = 1; d < ND; d++) begin
      if ((v >> (4 * d)) == 16'h0) lz_of[d] = 1'b1;
    end
`endif
  endfunction

  // Drive one cycle of inputs, predict the outputs after the edge, then compare.
  task automatic step(input logic r, input logic l, input logic [15:0] v);
    logic [3:0] ea;
    logic [3:0] en;
    logic       et;
    int         ph;
    int         dg;
    rst   = r;
    load  = l;
    value = v;
    @(posedge clk);
    if (r) begin
      ea    = 4'hF;
      en    = 4'h0;
      et    = 1'b0;
      t     = 0;
      mval  = 16'h0;
      mmask = 4'h0;
    end else begin
      ph = t % RD;
      dg = (t / RD) % ND;
      et = (ph == 0);
      en = 4'((mval >> (4 * dg)) & 16'hF);
      ea = 4'hF;
      if (ph != 0 && mmask[dg] == 1'b0) ea[dg] = 1'b0;
      mmask = lz_of(mval);
      if (l) mval = v;
      t++;
    end
    #1;
    chk("anode", {28'h0, anode}, {28'h0, ea});
    chk("nibble", {28'h0, nibble}, {28'h0, en});
    chk("slot_tick", {31'h0, slot_tick}, {31'h0, et});
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    logic        r;
    logic        l;
    logic [15:0] v;
    rst   = 1'b1;
    load  = 1'b0;
    value = 16'h0;
    @(negedge clk);

    // Reset held with a load that must be discarded, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'hFFFF);
    run(2);

    // Scan order over two frames.
    step(1'b0, 1'b1, 16'h1234);
    run(2 * ND * RD);

    // Load in the middle of digit 2's drive phase.
    while (!(((t / RD) % ND) == 2 && (t % RD) == 2)) step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'hABCD);
    run(6);

    // Load on the edge that ends a slot.
    while ((t % RD) != 3) step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h5A3C);
    run(8);

    // Reset during digit 3's drive phase together with a load.
    while ((t % (ND * RD)) != 14) step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'h9999);
    run(ND * RD + 2);

    // Leading-zero patterns.
    step(1'b0, 1'b1, 16'h0050);
    run(2 * ND * RD);
    step(1'b0, 1'b1, 16'h0000);
    run(2 * ND * RD);
    step(1'b0, 1'b1, 16'h0700);
    run(ND * RD + 3);

    // Randomized loads and occasional resets.
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      l = ($urandom_range(0, 4) == 0);
      v = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
      step(r, l, v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
